// File: rtl/iter_fixed_multiplier.sv
// Iterative signed/unsigned fixed-point multiplier.
//
// Operands are reduced to magnitudes. The magnitude of b is then consumed
// BITS_PER_CYCLE bits per cycle by shift-add into a 2*C_WIDTH accumulator.
// The product is scaled right by FIXED_POINT, optionally rounded half up,
// optionally saturated, and finally re-signed.
//
// Optional feature macro: ITER_MUL_SATURATE_EN
//   defined   - overflow saturates y to the mode limit; ovf reports overflow
//   undefined - y wraps to the low C_WIDTH bits; ovf is constant 0
//
// Ports:
//   ctl_clk     in   clock, rising edge
//   reset       in   synchronous active-low reset
//   a, b        in   multiplicand / multiplier (C_WIDTH)
//   signed_cal  in   1 = two's-complement operands/result, 0 = unsigned
//   trigger     in   start request, accepted while ready = 1
//   ready       out  idle, can accept trigger
//   done        out  one-cycle pulse, y/ovf valid
//   y           out  registered result, held until next done
//   ovf         out  registered overflow flag
module iter_fixed_multiplier #(
  parameter int unsigned C_WIDTH        = 32,
  parameter int unsigned FIXED_POINT    = 8,
  parameter int unsigned BITS_PER_CYCLE = 2,
  parameter int unsigned ROUND          = 1
) (
  input  logic               ctl_clk,
  input  logic               reset,
  input  logic [C_WIDTH-1:0] a,
  input  logic [C_WIDTH-1:0] b,
  input  logic               signed_cal,
  input  logic               trigger,
  output logic               ready,
  output logic               done,
  output logic [C_WIDTH-1:0] y,
  output logic               ovf
);

  localparam int unsigned ITER    = C_WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CNT_W   = (ITER > 1) ? $clog2(ITER) : 1;
  localparam int unsigned PW      = 2 * C_WIDTH;
  localparam int unsigned RND_IDX = (FIXED_POINT > 0) ? FIXED_POINT - 1 : 0;

  typedef enum logic [1:0] {StIdle, StCalc, StFinish} state_e;

  state_e             state;
  logic [CNT_W-1:0]   cnt;
  logic [PW-1:0]      mcand;    // |a|, shifted left as digits of |b| are consumed
  logic [C_WIDTH-1:0] mplier;   // |b|, shifted right; low bits are the current digit
  logic [PW-1:0]      acc;
  logic               neg;
  logic               mode;

  logic [C_WIDTH-1:0] a_mag, b_mag;
  logic [PW-1:0]      partial;
  logic [PW-1:0]      scaled, mag;
  logic               rnd;
  logic [C_WIDTH-1:0] sel;
  logic [C_WIDTH-1:0] y_next;
  logic               ovf_next;

  always_comb begin
    a_mag = (signed_cal && a[C_WIDTH-1]) ? (~a + C_WIDTH'(1)) : a;
    b_mag = (signed_cal && b[C_WIDTH-1]) ? (~b + C_WIDTH'(1)) : b;
  end

  // Shift-add of |a| times the current BITS_PER_CYCLE-bit digit of |b|.
  always_comb begin
    partial = '0;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      if (mplier[j]) partial = partial + (mcand << j);
    end
  end

  always_comb begin
    scaled = acc >> FIXED_POINT;
    rnd    = (ROUND != 0 && FIXED_POINT > 0) ? acc[RND_IDX] : 1'b0;
    mag    = scaled + PW'(rnd);
  end

`ifdef ITER_MUL_SATURATE_EN
  localparam logic [PW-1:0] LIM_SPOS = (PW'(1) << (C_WIDTH - 1)) - PW'(1);
  localparam logic [PW-1:0] LIM_SNEG = PW'(1) << (C_WIDTH - 1);
  localparam logic [PW-1:0] LIM_U    = (PW'(1) << C_WIDTH) - PW'(1);

  logic [PW-1:0] limit;

  // A full-width compare also catches any set bits above C_WIDTH+FIXED_POINT.
  always_comb begin
    limit    = mode ? (neg ? LIM_SNEG : LIM_SPOS) : LIM_U;
    ovf_next = (mag > limit);
    sel      = ovf_next ? limit[C_WIDTH-1:0] : mag[C_WIDTH-1:0];
  end
`else
  logic unused_wrap;
  assign unused_wrap = ^{mag[PW-1:C_WIDTH], mode};

  always_comb begin
    ovf_next = 1'b0;
    sel      = mag[C_WIDTH-1:0];
  end
`endif

  // A zero magnitude is never negated.
  assign y_next = (neg && sel != '0) ? (~sel + C_WIDTH'(1)) : sel;

  always_ff @(posedge ctl_clk) begin
    if (!reset) begin
      state  <= StIdle;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      neg    <= 1'b0;
      mode   <= 1'b0;
      ready  <= 1'b1;
      done   <= 1'b0;
      y      <= '0;
      ovf    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (trigger) begin
            mcand  <= {{C_WIDTH{1'b0}}, a_mag};
            mplier <= b_mag;
            neg    <= (a[C_WIDTH-1] ^ b[C_WIDTH-1]) & signed_cal;
            mode   <= signed_cal;
            acc    <= '0;
            cnt    <= '0;
            ready  <= 1'b0;
            state  <= StCalc;
          end
        end
        StCalc: begin
          acc    <= acc + partial;
          mcand  <= mcand << BITS_PER_CYCLE;
          mplier <= mplier >> BITS_PER_CYCLE;
          if (cnt == CNT_W'(ITER - 1)) begin
            state <= StFinish;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        StFinish: begin
          y     <= y_next;
          ovf   <= ovf_next;
          done  <= 1'b1;
          ready <= 1'b1;
          state <= StIdle;
        end
        default: begin
          ready <= 1'b1;
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iter_fixed_multiplier.sv
module tb_iter_fixed_multiplier;

  logic        ctl_clk = 1'b0;
  logic        reset;
  logic [15:0] a, b;
  logic        signed_cal;
  logic        trigger;
  logic        ready, done, ovf;
  logic [15:0] y;
  logic        ready_r0, done_r0, ovf_r0;
  logic [15:0] y_r0;

  int total = 0;
  int bad   = 0;
  int lat;
  int acc_cnt, done_cnt, second_acc;

  always #5 ctl_clk = ~ctl_clk;

  iter_fixed_multiplier #(
    .C_WIDTH(16), .FIXED_POINT(8), .BITS_PER_CYCLE(2), .ROUND(1)
  ) dut (
    .ctl_clk(ctl_clk), .reset(reset), .a(a), .b(b), .signed_cal(signed_cal),
    .trigger(trigger), .ready(ready), .done(done), .y(y), .ovf(ovf)
  );

  // Truncating twin, driven with the same stimulus.
  iter_fixed_multiplier #(
    .C_WIDTH(16), .FIXED_POINT(8), .BITS_PER_CYCLE(2), .ROUND(0)
  ) dut_r0 (
    .ctl_clk(ctl_clk), .reset(reset), .a(a), .b(b), .signed_cal(signed_cal),
    .trigger(trigger), .ready(ready_r0), .done(done_r0), .y(y_r0), .ovf(ovf_r0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One operation: trigger, scramble inputs during CALC, measure latency, check result.
  task automatic run_op(input string tag, input logic [15:0] ia, input logic [15:0] ib,
                        input logic is, input logic [15:0] ey, input logic eovf);
    @(negedge ctl_clk);
    check({tag, " ready"}, 32'(ready), 32'd1);
    a = ia; b = ib; signed_cal = is; trigger = 1'b1;
    @(negedge ctl_clk);
    trigger = 1'b0; a = ~ia; b = ~ib; signed_cal = ~is;
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge ctl_clk);
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'd9);
    check({tag, " y"}, 32'(y), 32'(ey));
    check({tag, " ovf"}, 32'(ovf), 32'(eovf));
    @(negedge ctl_clk);
    check({tag, " done_width"}, 32'(done), 32'd0);
  endtask

  initial begin
    reset = 1'b0; a = '0; b = '0; signed_cal = 1'b0; trigger = 1'b0;
    repeat (2) @(negedge ctl_clk);
    check("rst ready", 32'(ready), 32'd1);
    check("rst done", 32'(done), 32'd0);
    check("rst y", 32'(y), 32'd0);
    check("rst ovf", 32'(ovf), 32'd0);
    reset = 1'b1;

    run_op("u1.5x2", 16'h0180, 16'h0200, 1'b0, 16'h0300, 1'b0);
    run_op("s-1.5x2", 16'hFE80, 16'h0200, 1'b1, 16'hFD00, 1'b0);
    run_op("s-1.5x-2", 16'hFE80, 16'hFE00, 1'b1, 16'h0300, 1'b0);
    run_op("uMaxx1", 16'hFFFF, 16'h0100, 1'b0, 16'hFFFF, 1'b0);
    run_op("sMinx1", 16'h8000, 16'h0100, 1'b1, 16'h8000, 1'b0);
    run_op("sZero", 16'h8000, 16'h0000, 1'b1, 16'h0000, 1'b0);
`ifdef ITER_MUL_SATURATE_EN
    run_op("satPos", 16'h7F00, 16'h0200, 1'b1, 16'h7FFF, 1'b1);
    run_op("satNeg", 16'h8000, 16'h0200, 1'b1, 16'h8000, 1'b1);
    run_op("satU", 16'hFFFF, 16'h0200, 1'b0, 16'hFFFF, 1'b1);
`else
    run_op("wrapPos", 16'h7F00, 16'h0200, 1'b1, 16'hFE00, 1'b0);
    run_op("wrapNeg", 16'h8000, 16'h0200, 1'b1, 16'h0000, 1'b0);
    run_op("wrapU", 16'hFFFF, 16'h0200, 1'b0, 16'hFFFE, 1'b0);
`endif
    run_op("rnd", 16'h0001, 16'h0080, 1'b0, 16'h0001, 1'b0);
    check("rnd trunc y", 32'(y_r0), 32'h0000);
    run_op("rndNeg", 16'hFFFF, 16'h0080, 1'b1, 16'hFFFF, 1'b0);
    check("rndNeg trunc y", 32'(y_r0), 32'h0000);

    // Trigger held high: accepts only while ready, one done per accept.
    @(negedge ctl_clk);
    a = 16'h0100; b = 16'h0100; signed_cal = 1'b0; trigger = 1'b1;
    acc_cnt = 0; done_cnt = 0; second_acc = -1;
    for (int i = 0; i < 35; i++) begin
      if (done) done_cnt++;
      if (ready) begin
        acc_cnt++;
        if (acc_cnt == 2) second_acc = i;
      end
      @(negedge ctl_clk);
    end
    trigger = 1'b0;
    for (int j = 0; j < 20; j++) begin
      if (done) done_cnt++;
      @(negedge ctl_clk);
    end
    check("hs accepts", 32'(acc_cnt), 32'd4);
    check("hs dones", 32'(done_cnt), 32'd4);
    check("hs back2back", 32'(second_acc), 32'd10);
    check("hs y", 32'(y), 32'h0100);

    // Reset during CALC cycle 4.
    a = 16'h0180; b = 16'h0200; signed_cal = 1'b0; trigger = 1'b1;
    @(negedge ctl_clk);
    trigger = 1'b0;
    repeat (3) @(negedge ctl_clk);
    reset = 1'b0;
    @(negedge ctl_clk);
    check("midrst ready", 32'(ready), 32'd1);
    check("midrst y", 32'(y), 32'd0);
    check("midrst ovf", 32'(ovf), 32'd0);
    check("midrst done", 32'(done), 32'd0);
    reset = 1'b1;
    done_cnt = 0;
    for (int k = 0; k < 15; k++) begin
      if (done) done_cnt++;
      @(negedge ctl_clk);
    end
    check("midrst no_done", 32'(done_cnt), 32'd0);
    run_op("postrst", 16'h0180, 16'h0200, 1'b0, 16'h0300, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
